// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions: address width, return-stack depth and next-pc select encoding.
// The select encoding is also consumed by decode for trace/debug.
package pc_sequencer_pkg;

    localparam int PC_AW     = 11;
    localparam int RAS_DEPTH = 8;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_TGT = 2'd1,
        NPC_RET = 2'd2
    } npc_sel_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch controller and the pc sequencer.
// master drives controls and target, slave returns pc, npc and return-stack status.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int AW = PC_AW
);
    logic          stall;
    logic          branch_taken;
    logic          jump;
    logic          call;
    logic          ret;
    logic [AW-1:0] target;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_ovf;
    logic          ras_unf;

    modport master (
        output stall, branch_taken, jump, call, ret, target,
        input  pc, npc, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  stall, branch_taken, jump, call, ret, target,
        output pc, npc, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Return-address LIFO on a circular array; a push when full overwrites the oldest entry.
// Latency: push/pop take effect at the next edge, top is read combinationally.
// Backpressure: none; misuse is reported through single-cycle ovf/unf events.
module ras_stack #(
    parameter int DW    = 11,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] push_data,
    output logic [DW-1:0] top,
    output logic          empty,
    output logic          full,
    output logic          ovf_evt,
    output logic          unf_evt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign top     = mem[ptr];
    // pop wins if both are ever raised together
    assign do_pop  = pop & ~empty;
    assign do_push = push & ~pop;
    assign ovf_evt = do_push & full;
    assign unf_evt = pop & empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (do_pop) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end else if (do_push) begin
            ptr <= ptr + PW'(1);
            if (!full)
                cnt <= cnt + CW'(1);
        end
    end

    // Storage is not reset; with a full stack ptr+1 lands on the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[ptr + PW'(1)] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register with next-fetch selection (ret > call > jump > branch > seq).
// Latency: controls sampled at edge N, new pc visible after edge N, no bubbles.
// Backpressure: stall freezes pc, return stack and sticky flags.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int            AW       = PC_AW,
    parameter int            DEPTH    = RAS_DEPTH,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    pc_sequencer_if.slave   bus
);
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_nxt;
    logic [AW-1:0] npc_w;
    logic [AW-1:0] ras_top;
    logic          ras_empty_w;
    logic          ras_full_w;
    logic          ras_push;
    logic          ras_pop;
    logic          ovf_evt;
    logic          unf_evt;
    logic          ovf_q;
    logic          unf_q;
    npc_sel_t      sel;

    assign npc_w = pc_q + AW'(1);

    always_comb begin
        sel      = NPC_SEQ;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (!bus.stall) begin
            if (bus.ret) begin
                // an empty-stack return falls through to pc+1
                ras_pop = 1'b1;
                if (!ras_empty_w)
                    sel = NPC_RET;
            end else if (bus.call) begin
                ras_push = 1'b1;
                sel      = NPC_TGT;
            end else if (bus.jump || bus.branch_taken) begin
                sel = NPC_TGT;
            end
        end
    end

    always_comb begin
        pc_nxt = npc_w;
        case (sel)
            NPC_TGT: pc_nxt = bus.target;
            NPC_RET: pc_nxt = ras_top;
            default: pc_nxt = npc_w;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!bus.stall) begin
            pc_q <= pc_nxt;
            if (ovf_evt)
                ovf_q <= 1'b1;
            if (unf_evt)
                unf_q <= 1'b1;
        end
    end

    ras_stack #(
        .DW    (AW),
        .DEPTH (DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (npc_w),
        .top       (ras_top),
        .empty     (ras_empty_w),
        .full      (ras_full_w),
        .ovf_evt   (ovf_evt),
        .unf_evt   (unf_evt)
    );

    assign bus.pc        = pc_q;
    assign bus.npc       = npc_w;
    assign bus.ras_empty = ras_empty_w;
    assign bus.ras_full  = ras_full_w;
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;

endmodule
